// File: rtl/proc_link_tx.sv
// proc_link_tx: CPU-side transmitter of a processor-to-router link.
// A small FIFO takes flits from the CPU and tags each one with its destination
// address and direction flags. A two-state sender drives them out with a
// two-phase req/ack handshake. link_ack is asynchronous to clk, so it is
// synchronised before use.
// Optional feature: define PROC_LINK_TX_CNT_EN to add a 16-bit tx_count output.
// tx_count counts completed handshakes.
module proc_link_tx #(
    parameter int n     = 32,
    parameter int DEPTH = 4,
    parameter int SRCX  = 0,
    parameter int SRCY  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_valid,
    output logic         cpu_ready,
    input  logic [1:0]   cpu_dst,
    input  logic [n-5:0] cpu_payload,
    output logic         link_req,
    input  logic         link_ack,
`ifdef PROC_LINK_TX_CNT_EN
    output logic [15:0]  tx_count,
`endif
    output logic [n-1:0] link_data
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic        SRCX_B  = SRCX[0];
    localparam logic        SRCY_B  = SRCY[0];

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    logic [n-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ack_s1_q, ack_s2_q, ack_s3_q;
    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [n-1:0]  data_q, data_d;
    logic          push, pop, ack_evt;
    logic          dx, dy;

    // A 1-bit "dst > src" comparison is true only for dst=1 with src=0.
    assign dx        = cpu_dst[1] & ~SRCX_B;
    assign dy        = cpu_dst[0] & ~SRCY_B;
    assign cpu_ready = (count_q < DEPTH_C);
    assign push      = cpu_valid & cpu_ready;
    assign ack_evt   = ack_s2_q ^ ack_s3_q;
    assign link_req  = req_q;
    assign link_data = data_q;

    // FIFO storage. Contents need no reset because count/pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cpu_dst[1], cpu_dst[0], dx, dy, cpu_payload};
        end
    end

    // FIFO pointers and occupancy. Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Two-flop synchroniser on link_ack, plus a third flop used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            ack_s3_q <= 1'b0;
        end else begin
            ack_s1_q <= link_ack;
            ack_s2_q <= ack_s1_q;
            ack_s3_q <= ack_s2_q;
        end
    end

    // Sender state, request phase and the held output flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    // Sender next state. An ack event that arrives while IDLE has no effect.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_evt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PROC_LINK_TX_CNT_EN
    logic [15:0] cnt_q;

    // Completed-handshake counter. It wraps from 0xFFFF to 0.
    always_ff @(posedge clk) begin
        if (rst)                               cnt_q <= '0;
        else if (state_q == WAIT_ACK && ack_evt) cnt_q <= cnt_q + 16'd1;
    end

    assign tx_count = cnt_q;
`endif

endmodule

// File: tb/tb_proc_link_tx.sv
// Bench for proc_link_tx. Directed scenarios run first, then a randomised phase.
// Every cycle is checked against a transaction-level model built from a queue.
module tb_proc_link_tx;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst, cpu_valid, cpu_ready, link_req, link_ack;
    logic [1:0]   cpu_dst;
    logic [N-5:0] cpu_payload;
    logic [N-1:0] link_data;
`ifdef PROC_LINK_TX_CNT_EN
    logic [15:0]  tx_count;
`endif

    always #5 clk = ~clk;

    proc_link_tx #(.n(N), .DEPTH(DEPTH), .SRCX(0), .SRCY(0)) dut (
        .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_dst(cpu_dst), .cpu_payload(cpu_payload), .link_req(link_req),
        .link_ack(link_ack),
`ifdef PROC_LINK_TX_CNT_EN
        .tx_count(tx_count),
`endif
        .link_data(link_data)
    );

    // Reference model state.
    logic [N-1:0] mq[$];
    logic         m_req;
    logic [N-1:0] m_data;
    bit           m_busy;
    bit   [2:0]   hist;     // last three sampled ack values, newest in bit 0
    int           m_txc;
    bit           m_acc;

    // Router-side auto acknowledge.
    bit           auto_ack, ack_pend;
    int           ack_cnt, ack_dly_max;

    // Observation.
    int           checks, errors, dut_toggles;
    logic         prev_req;
    logic [N-5:0] seen[$];

    function automatic logic [N-1:0] mk_flit(input logic [1:0] d, input logic [N-5:0] p);
        logic dx, dy;
        dx = (d[1] > 1'b0);
        dy = (d[0] > 1'b0);
        return {d[1], d[0], dx, dy, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit evt, was_rst;
        // Router response: toggle ack once the chosen delay has elapsed.
        if (auto_ack && ack_pend) begin
            if (ack_cnt == 0) begin
                link_ack = ~link_ack;
                ack_pend = 0;
            end else begin
                ack_cnt--;
            end
        end
        was_rst = rst;
        m_acc   = 0;
        if (rst) begin
            mq.delete();
            m_req = 0; m_data = '0; m_busy = 0; hist = '0; m_txc = 0; ack_pend = 0;
        end else begin
            // An ack event is visible two samples after the ack changes.
            evt   = hist[1] ^ hist[2];
            m_acc = cpu_valid && (mq.size() < DEPTH);
            if (m_busy) begin
                if (evt) begin
                    m_busy = 0;
                    m_txc  = (m_txc + 1) & 16'hFFFF;
                end
            end else if (mq.size() > 0) begin
                m_data   = mq.pop_front();
                m_req    = ~m_req;
                m_busy   = 1;
                ack_pend = 1;
                ack_cnt  = $urandom_range(ack_dly_max, 0);
            end
            if (m_acc) mq.push_back(mk_flit(cpu_dst, cpu_payload));
            hist = {hist[1:0], link_ack};
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            prev_req = link_req;
        end else if (link_req !== prev_req) begin
            dut_toggles++;
            seen.push_back(link_data[N-5:0]);
            prev_req = link_req;
        end
        chk("link_req", link_req, m_req);
        chk("link_data", link_data, m_data);
        chk("cpu_ready", cpu_ready, (mq.size() < DEPTH));
`ifdef PROC_LINK_TX_CNT_EN
        chk("tx_count", tx_count, m_txc[15:0]);
`endif
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int t0, k, guard, s0;
        logic [1:0] dsts[3];
        logic [3:0] hdrs[3];
        checks = 0; errors = 0; dut_toggles = 0;
        auto_ack = 0; ack_pend = 0; ack_cnt = 0; ack_dly_max = 0;
        rst = 1; cpu_valid = 0; cpu_dst = '0; cpu_payload = '0; link_ack = 0;
        prev_req = 0;

        // Reset state.
        ticks(2);
        rst = 0;
        tick();
        chk("rst_ready", cpu_ready, 1'b1);
        chk("rst_req", link_req, 1'b0);
        chk("rst_data", link_data, 32'h0);

        // Single flit: send it, then acknowledge it by hand.
        cpu_valid = 1; cpu_dst = 2'b11; cpu_payload = 28'hFFFFFFF;
        tick();
        cpu_valid = 0;
        tick();
        chk("single_data", link_data, 32'hFFFFFFFF);
        chk("single_req", link_req, 1'b1);
        ticks(3);
        link_ack = ~link_ack; ack_pend = 0;
        ticks(5);
        chk("single_req_hold", link_req, 1'b1);

        // Header flags.
        auto_ack = 1; ack_dly_max = 2;
        dsts[0] = 2'b10; dsts[1] = 2'b01; dsts[2] = 2'b00;
        hdrs[0] = 4'hA;  hdrs[1] = 4'h5;  hdrs[2] = 4'h0;
        for (int i = 0; i < 3; i++) begin
            cpu_valid = 1; cpu_dst = dsts[i]; cpu_payload = 28'h1234567 + 28'(i);
            tick();
            cpu_valid = 0;
            tick();
            chk($sformatf("hdr%0d", i), link_data[31:28], hdrs[i]);
            ticks(8);
        end

        // Burst of 6 with valid held and ack one cycle after each req.
        ack_dly_max = 0;
        t0 = dut_toggles; s0 = seen.size();
        k = 1; guard = 0;
        while (k <= 6 && guard < 200) begin
            cpu_valid = 1; cpu_dst = 2'b01; cpu_payload = 28'(k);
            tick();
            if (m_acc) k++;
            guard++;
        end
        cpu_valid = 0;
        chk("burst_accept_timeout", (guard < 200), 1'b1);
        ticks(40);
        chk("burst_toggles", dut_toggles - t0, 6);
        for (int i = 0; i < 6; i++) begin
            if (s0 + i < seen.size()) chk($sformatf("burst_pl%0d", i + 1), seen[s0 + i], 28'(i + 1));
            else chk($sformatf("burst_pl%0d_missing", i + 1), 1'b0, 1'b1);
        end

        // Spurious ack while idle: it must not complete the next transfer.
        auto_ack = 0;
        link_ack = ~link_ack;
        ticks(6);
        t0 = dut_toggles;
        cpu_valid = 1; cpu_dst = 2'b11; cpu_payload = 28'hABCDEF0;
        tick();
        cpu_valid = 0;
        ticks(8);
        chk("spur_one_toggle", dut_toggles - t0, 1);
        link_ack = ~link_ack; ack_pend = 0;
        ticks(5);
        cpu_valid = 1; cpu_payload = 28'h0000042;
        tick();
        cpu_valid = 0;
        ticks(3);
        chk("spur_resume", dut_toggles - t0, 2);

        // Reset while waiting for ack, with 3 flits queued.
        for (int i = 0; i < 4; i++) begin
            cpu_valid = 1; cpu_payload = 28'(16 + i);
            tick();
        end
        cpu_valid = 0;
        ticks(2);
        rst = 1; link_ack = 0;
        tick();
        rst = 0;
        chk("rstw_req", link_req, 1'b0);
        chk("rstw_ready", cpu_ready, 1'b1);
        t0 = dut_toggles;
        ticks(6);
        chk("rstw_no_toggle", dut_toggles - t0, 0);

`ifdef PROC_LINK_TX_CNT_EN
        // Handshake counter: 5 flits since reset, then clear on reset.
        auto_ack = 1; ack_dly_max = 1;
        for (int i = 0; i < 5; i++) begin
            cpu_valid = 1; cpu_payload = 28'(100 + i);
            tick();
            cpu_valid = 0;
            ticks(7);
        end
        ticks(10);
        chk("cnt_5", tx_count, 16'd5);
        rst = 1; link_ack = 0;
        tick();
        rst = 0;
        tick();
        chk("cnt_rst", tx_count, 16'd0);
`endif

        // Randomised traffic with random ack latency; the model checks every cycle.
        auto_ack = 1; ack_dly_max = 4;
        for (int i = 0; i < 400; i++) begin
            cpu_valid   = ($urandom_range(3, 0) != 0);
            cpu_dst     = 2'($urandom_range(3, 0));
            cpu_payload = 28'($urandom);
            tick();
        end
        cpu_valid = 0;
        ticks(80);
        chk("rand_drained_ready", cpu_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
